// File: rtl/id_stage_pkg.sv
// id_stage_pkg: opcode constants, immediate formats and FSM states for the decode stage.
package id_stage_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {IMM_Z, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT} state_t;

    // The full 7-bit compare also rejects encodings whose inst[1:0] is not 2'b11.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
            OP_OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM, OP_OP_IMM_32, OP_OP_32: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OP_IMM,
            OP_OP, OP_OP_IMM_32, OP_OP_32, OP_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic imm_t imm_sel(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_SYSTEM: return IMM_I;
            OP_STORE: return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL: return IMM_J;
            default: return IMM_Z;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch, regfile and execute-side signals of the decode stage.
interface id_stage_if;
    logic        id_fetched_req_i;
    logic        id_fetched_ack_o;
    logic [63:0] id_pc_i;
    logic [31:0] id_inst_i;
    logic [4:0]  id_rs1_addr_o;
    logic [4:0]  id_rs2_addr_o;
    logic [63:0] id_rs1_data_i;
    logic [63:0] id_rs2_data_i;
    logic        id_decoded_req_o;
    logic        id_decoded_ack_i;
    logic        id_flush_i;
    logic [63:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [6:0]  id_opcode_o;
    logic [2:0]  id_funct3_o;
    logic [6:0]  id_funct7_o;
    logic [4:0]  id_rd_addr_o;
    logic        id_rd_wen_o;
    logic [63:0] id_op1_o;
    logic [63:0] id_op2_o;
    logic [63:0] id_imm_o;
    logic        id_illegal_o;

    modport slave (
        input  id_fetched_req_i, id_pc_i, id_inst_i, id_rs1_data_i, id_rs2_data_i,
               id_decoded_ack_i, id_flush_i,
        output id_fetched_ack_o, id_rs1_addr_o, id_rs2_addr_o, id_decoded_req_o,
               id_pc_o, id_inst_o, id_opcode_o, id_funct3_o, id_funct7_o, id_rd_addr_o,
               id_rd_wen_o, id_op1_o, id_op2_o, id_imm_o, id_illegal_o
    );

    modport master (
        output id_fetched_req_i, id_pc_i, id_inst_i, id_rs1_data_i, id_rs2_data_i,
               id_decoded_ack_i, id_flush_i,
        input  id_fetched_ack_o, id_rs1_addr_o, id_rs2_addr_o, id_decoded_req_o,
               id_pc_o, id_inst_o, id_opcode_o, id_funct3_o, id_funct7_o, id_rd_addr_o,
               id_rd_wen_o, id_op1_o, id_op2_o, id_imm_o, id_illegal_o
    );
endinterface

// File: rtl/id_imm_gen.sv
// id_imm_gen: sign-extended 64-bit immediate for each RISC-V instruction format.
module id_imm_gen
    import id_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_t        imm_type,
    output logic [63:0] imm
);
    always_comb
        imm = imm_type == IMM_I ? {{52{inst[31]}}, inst[31:20]} :
              imm_type == IMM_S ? {{52{inst[31]}}, inst[31:25], inst[11:7]} :
              imm_type == IMM_B ? {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
              imm_type == IMM_U ? {{32{inst[31]}}, inst[31:12], 12'b0} :
              imm_type == IMM_J ? {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
              64'h0;
endmodule

// File: rtl/id_stage.sv
// id_stage: captures a fetched instruction, decodes it in one cycle and holds
// the registered bundle until execute accepts it.
module id_stage
    import id_stage_pkg::*;
(
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);
    state_t      state;
    logic [63:0] pc_q;
    logic [31:0] inst_q;
    logic [63:0] imm;

    id_imm_gen u_imm_gen (
        .inst     (inst_q),
        .imm_type (imm_sel(inst_q[6:0])),
        .imm      (imm)
    );

    assign bus.id_rs1_addr_o = inst_q[19:15];
    assign bus.id_rs2_addr_o = inst_q[24:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            pc_q                 <= '0;
            inst_q               <= '0;
            bus.id_fetched_ack_o <= 1'b0;
            bus.id_decoded_req_o <= 1'b0;
            bus.id_pc_o          <= '0;
            bus.id_inst_o        <= '0;
            bus.id_opcode_o      <= '0;
            bus.id_funct3_o      <= '0;
            bus.id_funct7_o      <= '0;
            bus.id_rd_addr_o     <= '0;
            bus.id_rd_wen_o      <= 1'b0;
            bus.id_op1_o         <= '0;
            bus.id_op2_o         <= '0;
            bus.id_imm_o         <= '0;
            bus.id_illegal_o     <= 1'b0;
        end else if (bus.id_flush_i) begin
            state                <= S_IDLE;
            bus.id_fetched_ack_o <= 1'b0;
            bus.id_decoded_req_o <= 1'b0;
        end else begin
            bus.id_fetched_ack_o <= 1'b0;
            case (state)
                S_IDLE: if (bus.id_fetched_req_i) begin
                    pc_q                 <= bus.id_pc_i;
                    inst_q               <= bus.id_inst_i;
                    bus.id_fetched_ack_o <= 1'b1;
                    state                <= S_DECODE;
                end
                S_DECODE: begin
                    bus.id_pc_o          <= pc_q;
                    bus.id_inst_o        <= inst_q;
                    bus.id_opcode_o      <= inst_q[6:0];
                    bus.id_funct3_o      <= inst_q[14:12];
                    bus.id_funct7_o      <= inst_q[31:25];
                    bus.id_rd_addr_o     <= inst_q[11:7];
                    bus.id_rd_wen_o      <= writes_rd(inst_q[6:0]) && inst_q[11:7] != 5'd0;
                    bus.id_op1_o         <= bus.id_rs1_data_i;
                    bus.id_op2_o         <= bus.id_rs2_data_i;
                    bus.id_imm_o         <= imm;
                    bus.id_illegal_o     <= !is_legal(inst_q[6:0]);
                    bus.id_decoded_req_o <= 1'b1;
                    state                <= S_WAIT;
                end
                S_WAIT: if (bus.id_decoded_ack_i) begin
                    bus.id_decoded_req_o <= 1'b0;
                    state                <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table plus handshake, flush and reset sequences for id_stage.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    id_stage_if bus();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rf(input logic [4:0] a);
        return a == 5'd0 ? 64'h0 : {32'hCAFE_0000, 27'h0, a} ^ {27'h0, a, 32'h0};
    endfunction

    always_comb begin
        bus.id_rs1_data_i = rf(bus.id_rs1_addr_o);
        bus.id_rs2_data_i = rf(bus.id_rs2_addr_o);
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] imm;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [63:0] pc, input logic [31:0] inst);
        @(negedge clk);
        bus.id_pc_i          = pc;
        bus.id_inst_i        = inst;
        bus.id_fetched_req_i = 1'b1;
        tick();
    endtask

    task automatic accept();
        @(negedge clk);
        bus.id_decoded_ack_i = 1'b1;
        tick();
        check("req_after_ack", bus.id_decoded_req_o, 0);
        @(negedge clk);
        bus.id_decoded_ack_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, bus.id_fetched_ack_o, 0);
        check({tag, "_req"}, bus.id_decoded_req_o, 0);
        check({tag, "_rs1"}, bus.id_rs1_addr_o, 0);
        check({tag, "_rs2"}, bus.id_rs2_addr_o, 0);
        check({tag, "_pc"}, bus.id_pc_o, 0);
        check({tag, "_inst"}, bus.id_inst_o, 0);
        check({tag, "_rd"}, bus.id_rd_addr_o, 0);
        check({tag, "_wen"}, bus.id_rd_wen_o, 0);
        check({tag, "_op1"}, bus.id_op1_o, 0);
        check({tag, "_op2"}, bus.id_op2_o, 0);
        check({tag, "_imm"}, bus.id_imm_o, 0);
        check({tag, "_ill"}, bus.id_illegal_o, 0);
    endtask

    initial begin
        //        pc                     inst          op     f3    f7     rd     wen   imm                      ill   rs1    rs2
        vecs[0] = '{64'h8000_0000, 32'h0050_0093, 7'h13, 3'd0, 7'h00, 5'd1,  1'b1, 64'h5,                   1'b0, 5'd0, 5'd5};
        vecs[1] = '{64'h8000_0004, 32'h0021_B423, 7'h23, 3'd3, 7'h00, 5'd8,  1'b0, 64'h8,                   1'b0, 5'd3, 5'd2};
        vecs[2] = '{64'h8000_0008, 32'hFE00_0EE3, 7'h63, 3'd0, 7'h7F, 5'd29, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd0, 5'd0};
        vecs[3] = '{64'h8000_000C, 32'h0010_00EF, 7'h6F, 3'd0, 7'h00, 5'd1,  1'b1, 64'h800,                 1'b0, 5'd0, 5'd1};
        vecs[4] = '{64'h8000_0010, 32'h0000_0000, 7'h00, 3'd0, 7'h00, 5'd0,  1'b0, 64'h0,                   1'b1, 5'd0, 5'd0};
        vecs[5] = '{64'h8000_0014, 32'h1234_52B7, 7'h37, 3'd5, 7'h09, 5'd5,  1'b1, 64'h1234_5000,           1'b0, 5'd8, 5'd3};
        vecs[6] = '{64'h8000_0018, 32'h0020_81B3, 7'h33, 3'd0, 7'h00, 5'd3,  1'b1, 64'h0,                   1'b0, 5'd1, 5'd2};
        vecs[7] = '{64'h8000_001C, 32'h0000_0013, 7'h13, 3'd0, 7'h00, 5'd0,  1'b0, 64'h0,                   1'b0, 5'd0, 5'd0};
        vecs[8] = '{64'h8000_0020, 32'h8000_00B7, 7'h37, 3'd0, 7'h40, 5'd1,  1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd0, 5'd0};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFF0, 32'h0050_0091, 7'h11, 3'd0, 7'h00, 5'd1, 1'b0, 64'h0, 1'b1, 5'd0, 5'd5};

        bus.id_fetched_req_i = 1'b0;
        bus.id_pc_i          = '0;
        bus.id_inst_i        = '0;
        bus.id_decoded_ack_i = 1'b0;
        bus.id_flush_i       = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            capture(vecs[i].pc, vecs[i].inst);
            check($sformatf("v%0d_ack", i), bus.id_fetched_ack_o, 1);
            check($sformatf("v%0d_req_early", i), bus.id_decoded_req_o, 0);
            @(negedge clk);
            bus.id_fetched_req_i = 1'b0;
            tick();
            check($sformatf("v%0d_ack_pulse", i), bus.id_fetched_ack_o, 0);
            check($sformatf("v%0d_req", i), bus.id_decoded_req_o, 1);
            check($sformatf("v%0d_pc", i), bus.id_pc_o, vecs[i].pc);
            check($sformatf("v%0d_inst", i), bus.id_inst_o, vecs[i].inst);
            check($sformatf("v%0d_opcode", i), bus.id_opcode_o, vecs[i].op);
            check($sformatf("v%0d_funct3", i), bus.id_funct3_o, vecs[i].f3);
            check($sformatf("v%0d_funct7", i), bus.id_funct7_o, vecs[i].f7);
            check($sformatf("v%0d_rd", i), bus.id_rd_addr_o, vecs[i].rd);
            check($sformatf("v%0d_wen", i), bus.id_rd_wen_o, vecs[i].wen);
            check($sformatf("v%0d_imm", i), bus.id_imm_o, vecs[i].imm);
            check($sformatf("v%0d_illegal", i), bus.id_illegal_o, vecs[i].ill);
            check($sformatf("v%0d_rs1", i), bus.id_rs1_addr_o, vecs[i].rs1);
            check($sformatf("v%0d_rs2", i), bus.id_rs2_addr_o, vecs[i].rs2);
            check($sformatf("v%0d_op1", i), bus.id_op1_o, rf(vecs[i].rs1));
            check($sformatf("v%0d_op2", i), bus.id_op2_o, rf(vecs[i].rs2));
            accept();
        end

        // Stall: consumer withholds ack while fetch keeps requesting.
        capture(64'h9000_0000, 32'h0010_00EF);
        check("stall_ack", bus.id_fetched_ack_o, 1);
        tick();
        check("stall_req", bus.id_decoded_req_o, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d_ack", i), bus.id_fetched_ack_o, 0);
            check($sformatf("stall%0d_req", i), bus.id_decoded_req_o, 1);
            check($sformatf("stall%0d_imm", i), bus.id_imm_o, 64'h800);
            check($sformatf("stall%0d_pc", i), bus.id_pc_o, 64'h9000_0000);
        end
        @(negedge clk);
        bus.id_fetched_req_i = 1'b0;
        bus.id_decoded_ack_i = 1'b1;
        tick();
        check("stall_release", bus.id_decoded_req_o, 0);
        @(negedge clk);
        bus.id_decoded_ack_i = 1'b0;
        tick();
        check("stall_idle_ack", bus.id_fetched_ack_o, 0);
        check("stall_idle_req", bus.id_decoded_req_o, 0);

        // Flush while decoding, then show IDLE accepts a new instruction.
        capture(64'h9000_0010, 32'h0050_0093);
        @(negedge clk);
        bus.id_fetched_req_i = 1'b0;
        bus.id_flush_i       = 1'b1;
        tick();
        check("flush_dec_req", bus.id_decoded_req_o, 0);
        check("flush_dec_ack", bus.id_fetched_ack_o, 0);
        @(negedge clk);
        bus.id_flush_i = 1'b0;
        tick();
        check("flush_dec_idle", bus.id_decoded_req_o, 0);
        capture(64'h9000_0014, 32'h1234_52B7);
        check("flush_dec_recapture", bus.id_fetched_ack_o, 1);
        @(negedge clk);
        bus.id_fetched_req_i = 1'b0;
        tick();
        check("flush_dec_new_imm", bus.id_imm_o, 64'h1234_5000);
        accept();

        // Flush in WAIT, alone and together with the consumer ack.
        for (int k = 0; k < 2; k++) begin
            capture(64'h9000_0020, 32'h0021_B423);
            @(negedge clk);
            bus.id_fetched_req_i = 1'b0;
            tick();
            check($sformatf("flush_wait%0d_pre", k), bus.id_decoded_req_o, 1);
            @(negedge clk);
            bus.id_flush_i       = 1'b1;
            bus.id_decoded_ack_i = k[0];
            tick();
            check($sformatf("flush_wait%0d_req", k), bus.id_decoded_req_o, 0);
            @(negedge clk);
            bus.id_flush_i       = 1'b0;
            bus.id_decoded_ack_i = 1'b0;
            capture(64'h9000_0024, 32'hFE00_0EE3);
            check($sformatf("flush_wait%0d_idle", k), bus.id_fetched_ack_o, 1);
            @(negedge clk);
            bus.id_fetched_req_i = 1'b0;
            tick();
            check($sformatf("flush_wait%0d_imm", k), bus.id_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
            accept();
        end

        // Flush beats capture in IDLE.
        @(negedge clk);
        bus.id_flush_i       = 1'b1;
        bus.id_fetched_req_i = 1'b1;
        bus.id_pc_i          = 64'h9000_0030;
        bus.id_inst_i        = 32'h0020_81B3;
        tick();
        check("flush_idle_ack", bus.id_fetched_ack_o, 0);
        @(negedge clk);
        bus.id_flush_i = 1'b0;
        tick();
        check("flush_idle_capture", bus.id_fetched_ack_o, 1);
        @(negedge clk);
        bus.id_fetched_req_i = 1'b0;
        tick();
        check("flush_idle_rd", bus.id_rd_addr_o, 3);

        // Reset in WAIT dominates flush and ack and clears everything.
        @(negedge clk);
        rst                  = 1'b1;
        bus.id_flush_i       = 1'b1;
        bus.id_decoded_ack_i = 1'b1;
        tick();
        check_zero("rst_wait");
        @(negedge clk);
        bus.id_flush_i       = 1'b0;
        bus.id_decoded_ack_i = 1'b0;
        bus.id_fetched_req_i = 1'b1;
        tick();
        check("rst_req_ack", bus.id_fetched_ack_o, 0);
        @(negedge clk);
        rst                  = 1'b0;
        bus.id_fetched_req_i = 1'b0;
        tick();
        check("rst_after_ack", bus.id_fetched_ack_o, 0);
        check("rst_after_req", bus.id_decoded_req_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
